// File: rtl/vector_sweep_checker.sv
// Exhaustive 2-input sweep of an external combinational block: drives each vector for
// HOLD_CYCLES clocks, samples the response on the last clock, and compares against an expected table.
module vector_sweep_checker #(
  parameter int HOLD_CYCLES = 20,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       dut_op,
  output logic       dut_i0,
  output logic       dut_i1,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [3:0] mismatch,
  output logic       pass
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       k;
  logic [1:0]       k_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       exp_q;
  logic             hold_end;

  assign hold_end = (cnt == CNT_LAST);
  assign k_nxt    = k + 2'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (hold_end && (k == 2'd3)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k        <= '0;
      cnt      <= '0;
      exp_q    <= '0;
      dut_i0   <= 1'b0;
      dut_i1   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      truth    <= '0;
      mismatch <= '0;
      pass     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_q    <= expected;
            truth    <= '0;
            mismatch <= '0;
            pass     <= 1'b0;
            k        <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            dut_i0   <= 1'b0;
            dut_i1   <= 1'b0;
          end
        end
        RUN: begin
          if (hold_end) begin
            truth[k] <= dut_op;
            cnt      <= '0;
            // next vector is driven from the same edge that samples the current one
            if (k != 2'd3) begin
              k                <= k_nxt;
              {dut_i1, dut_i0} <= k_nxt;
            end else begin
              {dut_i1, dut_i0} <= 2'b00;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          mismatch <= truth ^ exp_q;
          pass     <= (truth == exp_q);
          k        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vector_sweep_checker.md
Name: vector_sweep_checker

Overview:
- Synthesizable on-chip stimulus generator and response checker for any 2-input, 1-output combinational module.
- Drives all four input vectors, holds each for a programmable number of clocks, samples the DUT output, builds a 4-bit truth table and compares it against an expected table.
- Sits on the DUT side opposite the simulation testbench, so a board build can self-check a combinational block without a simulator.

Parameters:
- HOLD_CYCLES, 20, clocks each vector is held before the DUT output is sampled; legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- expected  input  4  expected truth table, bit k = DUT output for vector k; sampled on accepted start.
- dut_op  input  1  DUT output.
- dut_i0  output  1  DUT input 0 (registered).
- dut_i1  output  1  DUT input 1 (registered).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when results are valid.
- truth  output  4  captured truth table.
- mismatch  output  4  truth XOR expected, valid with done.
- pass  output  1  high when mismatch == 0, valid with done and held after.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - dut_i0=0, dut_i1=0, busy=0, done=0, truth=0, mismatch=0, pass=0.
  - Vector index and hold counter cleared.
  - Release is synchronous to clk.
- Vector order, index k=0..3: k0 (i0=0,i1=0), k1 (1,0), k2 (0,1), k3 (1,1).
  - dut_i0=k[0], dut_i1=k[1].
  - truth[k] holds the sampled DUT output for vector k.
- States:
  - IDLE:
    - Outputs hold the last results; dut_i0/dut_i1 held at 0.
    - start=1: latch expected, clear truth, mismatch and pass, set k=0, cnt=0, busy=1, go RUN.
  - RUN:
    - Each cycle cnt increments.
    - When cnt==HOLD_CYCLES-1, register truth[k]<=dut_op.
    - If k<3: k<=k+1, cnt<=0, and dut_i0/dut_i1 update on that same edge.
    - If k==3: go DONE.
    - Each vector is therefore driven for exactly HOLD_CYCLES clocks, and dut_op is sampled on the final clock of the hold.
  - DONE (one cycle):
    - done=1, busy=0.
    - mismatch=truth^latched expected; pass=(mismatch==0).
    - dut_i0/dut_i1 return to 0.
    - Next state IDLE.
- Latency: start accepted at edge E0; done asserted for the cycle after edge E0+4*HOLD_CYCLES+1.
- start while busy or in DONE is ignored, with no restart. expected changing mid-sweep has no effect.
- Reset mid-sweep aborts immediately to the reset values; the partial truth table is discarded.
- After done, truth/mismatch/pass stay stable until the next accepted start or reset.
- DUT path is combinational; the checker adds no synchronisers on dut_op.

Test Plan:
- AND DUT, HOLD_CYCLES=20, expected=4'b1000, one start pulse -> dut inputs sequence 00,10,01,11 each held 20 clk; truth=1000; mismatch=0000; pass=1; done pulses once, 82 cycles after start edge; busy high for 81 cycles.
- XOR DUT, expected=4'b0110 -> truth=0110, pass=1. Rerun with expected=4'b1110 -> truth=0110, mismatch=1000, pass=0.
- Mystery/OR DUT with expected=4'b0000 -> truth=1110, mismatch=1110, pass=0. Results hold unchanged for 50 idle cycles afterwards.
- start pulsed again at cycles 5 and 40 of a running sweep, expected toggled mid-run -> no restart; completion timing and results identical to the undisturbed run.
- reset_n driven low asynchronously mid-vector k2, between clock edges -> dut_i0/dut_i1/busy/truth go 0 without waiting for a clock edge, done never pulses. A new start after release gives a full correct sweep.
- HOLD_CYCLES=2 with AND DUT -> each vector held exactly 2 clk; done 10 cycles after start edge; truth=1000, pass=1.
